// File: rtl/riscv_lsu_v1.sv
// Load/store unit driving the memory_v1 port: word addressing, sub-word RMW stores, load extension.
// Optional LSU_STATS_EN adds saturating load/store/error response counters.
module riscv_lsu_v1 #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_wren
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q;

  logic        accept, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext, merged;

  logic              ready_d, valid_d, err_d, wren_d;
  logic [31:0]       rdata_d, din_d;
  logic [ADDR_W-1:0] addr_d;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign accept  = req_valid && req_ready;
  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= 2'(READ_LATENCY);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata;
      end else if (state == RD_WAIT) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // RD_WAIT is left on the edge the counter reaches 0; memory data is then
  // sampled one edge later by the registered outputs of WRITE/RESP.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                     state_nx = RESP;
          else if (req_we && req_size == 2'b10) state_nx = WRITE;
          else                             state_nx = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt == 2'd1) state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    unique case (lane_q)
      2'd0:    byte_sel = mem_data_out[7:0];
      2'd1:    byte_sel = mem_data_out[15:8];
      2'd2:    byte_sel = mem_data_out[23:16];
      default: byte_sel = mem_data_out[31:24];
    endcase
    half_sel = lane_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];

    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_data_out;
    endcase

    merged = mem_data_out;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    ready_d = (state == IDLE) && !accept;
    valid_d = (state == RESP);
    err_d   = (state == RESP) && err_q;
    rdata_d = (state == RESP && !err_q && !we_q) ? load_ext : '0;
    wren_d  = (state == WRITE);
    addr_d  = accept ? req_addr[ADDR_W+1:2] : mem_addr;
    din_d   = mem_data_in;
    if (state == WRITE) din_d = (size_q == 2'b10) ? wdata_q : merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_wren    <= 1'b0;
    end else begin
      req_ready   <= ready_d;
      resp_valid  <= valid_d;
      resp_err    <= err_d;
      resp_rdata  <= rdata_d;
      mem_addr    <= addr_d;
      mem_data_in <= din_d;
      mem_wren    <= wren_d;
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 16'd1;
      end else if (we_q) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/riscv_lsu_v1.md
Name: riscv_lsu_v1

Overview:
- Load/store unit: the initiator side of the memory_v1 port. It drives mem_addr, data_in and write_enable, and consumes data_out.
- Accepts one core load/store request at a time and translates byte addresses to word addresses.
- Performs read-modify-write for byte and halfword stores, and sign/zero-extends sub-word loads.
- Sits between the RISC-V core execute stage and memory_v1, including the memory-mapped switches, buttons, seven-segment and pmod registers.

Parameters:
- ADDR_W, 10, memory word-address width (matches memory_v1 mem_addr).
- READ_LATENCY, 1, clock edges from address presented to data_out valid; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request; qualified by resp_valid.
- mem_addr  out  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
- mem_data_in  out  32  write data to memory.
- mem_data_out  in  32  read data from memory.
- mem_wren  out  1  memory write enable.

Behaviour:
- Reset: all outputs are registered.
  - Asynchronous rst forces state IDLE.
  - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_addr=0, mem_data_in=0, mem_wren=0.
  - Reset mid-operation aborts the transaction. A pending RMW write is never issued and no resp_valid is produced.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - resp_valid has no backpressure and is high for exactly one cycle.
  - req_ready is high again in the cycle after resp_valid.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE, on accept, latches all request fields.
  - Misaligned or illegal request: half with addr[0]=1, word with addr[1:0]≠0, or size 11. Next state RESP with resp_err=1; no memory access.
  - Load: drive mem_addr, load the wait counter with READ_LATENCY, go to RD_WAIT.
  - Word store: drive mem_addr and mem_data_in=req_wdata, set mem_wren=1, go to WRITE.
  - Byte/half store: drive mem_addr, go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each edge.
  - On the edge after it reaches 0, sample mem_data_out.
  - Load: extract the lane and extend into resp_rdata, then go to RESP.
  - Sub-word store: merge req_wdata into the addressed lane(s) of the sampled word, set mem_data_in to the merged word and mem_wren=1, go to WRITE.
- WRITE: mem_wren is high for exactly this one cycle; the next state is RESP and mem_wren returns to 0.
- RESP: resp_valid=1; the next state is IDLE.
- Lanes are little-endian.
  - Byte lane is addr[1:0]; half lane is addr[1].
  - Sign extension takes bit 7 or bit 15 of the extracted lane unless req_unsigned=1.
  - req_unsigned is ignored for word loads and for stores.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo memory size).
- Latency, counted from the accept edge E0:
  - Error: resp_valid after E1.
  - Word store: mem_wren after E1, resp_valid after E2.
  - Load: resp_valid after E(READ_LATENCY+1).
  - Sub-word store: mem_wren after E(READ_LATENCY+1), resp_valid after E(READ_LATENCY+2).
- mem_addr holds its value from accept until a new request is accepted.
- req_valid held high through a busy period is accepted on the first IDLE edge.

Optional Feature:
- Macro: LSU_STATS_EN.
- When defined, three 16-bit output ports are added: stat_loads, stat_stores, stat_errs.
  - Each increments on the edge its transaction's resp_valid is asserted.
  - Each saturates at 16'hFFFF and resets to 0.
  - An error response counts only in stat_errs.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Word store then load: store addr 0x10, 0xDEADBEEF → mem_wren after E1 with mem_addr=4; then LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store RMW: memory word 4 = 0x11223344, SB addr 0x12 data 0xAB → one memory read, then mem_data_in=0x11AB3344 with mem_wren pulsed exactly once.
- Sign/zero extension: word = 0x80F0_7F81:
  - LB 0x0 → 0xFFFFFF81; LBU 0x0 → 0x00000081.
  - LH 0x2 → 0xFFFF80F0; LHU 0x2 → 0x000080F0.
- Misalignment: LW 0x13 and SH 0x01 → resp_err=1 after E1, resp_rdata=0, mem_wren never asserted, memory unchanged.
- Back-to-back with req_valid held high: req_ready low while busy; second request accepted the cycle after the first resp_valid; READ_LATENCY=2 load responds after E3.
- Reset mid-RMW: assert rst in RD_WAIT of SB → mem_wren stays 0, no resp_valid, target word unchanged, req_ready=1 immediately.
